// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a small transmit FIFO; frames leave back-to-back while data is queued.
// Optional parity bit (port par_odd, PARITY state) is built in when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tx_start,
  input  logic [DATA_BITS-1:0]              tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic                              par_odd,
`endif
  output logic                              tx_rdy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt,
  output logic                              tx_busy,
  output logic                              tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int DW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------- transmit FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign tx_rdy   = (cnt_reg != CW'(FIFO_DEPTH));
  assign push     = tx_start && tx_rdy;
  assign fifo_cnt = cnt_reg;
  assign head     = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  state_t               state_reg, state_next;
  logic [DW-1:0]        baud_reg, baud_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg;
  logic                 tick;

`ifdef UART_TX_PARITY_EN
  logic par_reg, par_next;
  logic head_par;
  // par_odd is folded in at pop so later changes cannot disturb a frame in flight
  assign head_par = (^head) ^ par_odd;
`endif

  assign tick    = (baud_reg == DW'(BAUD_DIV-1));
  assign tx      = tx_reg;
  assign tx_busy = busy_reg;

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = 1'b1;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    if (state_reg != S_IDLE) baud_next = tick ? '0 : baud_reg + 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (cnt_reg != '0) begin
          pop        = 1'b1;
          shift_next = head;
`ifdef UART_TX_PARITY_EN
          par_next   = head_par;
`endif
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_START;
        end
      end
      S_START: begin
        tx_next = 1'b0;
        if (tick) begin
          bit_next   = '0;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        tx_next = shift_reg[0];
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == BW'(DATA_BITS-1)) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_next = par_reg;
        if (tick) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          if (bit_reg == BW'(STOP_BITS-1)) begin
            bit_next = '0;
            // chain straight into the next start bit when more data is waiting
            if (cnt_reg != '0) begin
              pop        = 1'b1;
              shift_next = head;
`ifdef UART_TX_PARITY_EN
              par_next   = head_par;
`endif
              state_next = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= (state_next != S_IDLE);
`ifdef UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: one 8N1/div16 instance and one 7-bit/2-stop/div8 instance.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB_A = 1 + 8 + P + 1;
  localparam int F_A  = NB_A * 16;
  localparam int NB_B = 1 + 7 + P + 2;
  localparam int F_B  = NB_B * 8;

  logic       clk, rst_n;
  logic       start_a, start_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       tx_a, busy_a, rdy_a;
  logic       tx_b, busy_b, rdy_b;
  logic [2:0] cnt_a, cnt_b;
`ifdef UART_TX_PARITY_EN
  logic       par_odd_a, par_odd_b;
`endif

  int total = 0;
  int bad   = 0;

  uart_tx_param #(.DATA_BITS(8), .BAUD_DIV(16), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_data(data_a),
`ifdef UART_TX_PARITY_EN
    .par_odd(par_odd_a),
`endif
    .tx_rdy(rdy_a), .fifo_cnt(cnt_a), .tx_busy(busy_a), .tx(tx_a)
  );

  uart_tx_param #(.DATA_BITS(7), .BAUD_DIV(8), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_data(data_b),
`ifdef UART_TX_PARITY_EN
    .par_odd(par_odd_b),
`endif
    .tx_rdy(rdy_b), .fifo_cnt(cnt_b), .tx_busy(busy_b), .tx(tx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit-time b of a frame: start, data LSB first, optional parity, stop(s).
  function automatic logic exp_bit(input int b, input logic [8:0] d, input int nb, input logic pb);
    if (b == 0) return 1'b0;
    if (b <= nb) return d[b-1];
    if (P == 1 && b == nb + 1) return pb;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt_a); end
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", rdy_a); end
    total++; if (tx_b !== 1'b1) begin bad++; $display("FAIL reset_tx_b got=%b want=1", tx_b); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if ({tx_a, busy_a, cnt_a} !== 5'b10000) begin
      bad++; $display("FAIL post_reset_idle got=%b want=10000", {tx_a, busy_a, cnt_a});
    end
    $display("reset: done");
  endtask

  task automatic test_single();
    logic [8:0] d;
    logic       pb, e;
    int         busy_n;
    d = 9'h0A5;
    pb = ^d;
    @(posedge clk); #1; start_a = 1'b1; data_a = 8'hA5;
    @(posedge clk); #1; start_a = 1'b0;
    total++; if (cnt_a !== 3'd1) begin bad++; $display("FAIL single_cnt_push got=%0d want=1", cnt_a); end
    busy_n = 0;
    for (int s = 0; s < F_A + 16; s++) begin
      @(posedge clk); #1;
      e = (s == 0 || s > F_A) ? 1'b1 : exp_bit((s - 1) / 16, d, 8, pb);
      total++; if (tx_a !== e) begin bad++; $display("FAIL single_tx s=%0d got=%b want=%b", s, tx_a, e); end
      if (busy_a === 1'b1) busy_n++;
    end
    total++; if (busy_n != F_A) begin bad++; $display("FAIL single_busy_len got=%0d want=%0d", busy_n, F_A); end
    total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL single_cnt_end got=%0d want=0", cnt_a); end
    $display("single: char=A5 busy_clocks=%0d", busy_n);
  endtask

  task automatic test_queue();
    logic [7:0] q [5];
    logic [7:0] pv [5];
    logic [8:0] d;
    logic       e;
    int         busy_n, fi;
    q[0] = 8'hA5; q[1] = 8'h11; q[2] = 8'h22; q[3] = 8'h33; q[4] = 8'h44;
    pv[0] = 8'h11; pv[1] = 8'h22; pv[2] = 8'h33; pv[3] = 8'h44; pv[4] = 8'h55;
    @(posedge clk); #1; start_a = 1'b1; data_a = 8'hA5;
    @(posedge clk); #1; start_a = 1'b0;
    busy_n = 0;
    for (int s = 0; s < 5 * F_A + 16; s++) begin
      @(posedge clk); #1;
      if (s == 0 || s > 5 * F_A) e = 1'b1;
      else begin
        fi = (s - 1) / F_A;
        d = {1'b0, q[fi]};
        e = exp_bit(((s - 1) % F_A) / 16, d, 8, ^d);
      end
      total++; if (tx_a !== e) begin bad++; $display("FAIL queue_tx s=%0d got=%b want=%b", s, tx_a, e); end
      if (busy_a === 1'b1) busy_n++;
      if (s == 7 || s == 10) begin
        total++; if (cnt_a !== 3'd4) begin bad++; $display("FAIL queue_full_cnt s=%0d got=%0d want=4", s, cnt_a); end
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL queue_full_rdy s=%0d got=%b want=0", s, rdy_a); end
      end
      if (s >= 2 && s <= 6) begin start_a = 1'b1; data_a = pv[s-2]; end
      else start_a = 1'b0;
    end
    total++; if (busy_n != 5 * F_A) begin bad++; $display("FAIL queue_busy_len got=%0d want=%0d", busy_n, 5 * F_A); end
    total++; if ({cnt_a, rdy_a} !== 4'b0001) begin bad++; $display("FAIL queue_end got=%b want=0001", {cnt_a, rdy_a}); end
    $display("queue: frames=5 busy_clocks=%0d", busy_n);
  endtask

  task automatic test_simul();
    logic [7:0] q [3];
    logic [8:0] d;
    logic       e;
    int         busy_n, fi;
    q[0] = 8'h5A; q[1] = 8'hC3; q[2] = 8'h3C;
    @(posedge clk); #1; start_a = 1'b1; data_a = q[0];
    @(posedge clk); #1; start_a = 1'b0;
    busy_n = 0;
    for (int s = 0; s < 3 * F_A + 16; s++) begin
      @(posedge clk); #1;
      if (s == 0 || s > 3 * F_A) e = 1'b1;
      else begin
        fi = (s - 1) / F_A;
        d = {1'b0, q[fi]};
        e = exp_bit(((s - 1) % F_A) / 16, d, 8, ^d);
      end
      total++; if (tx_a !== e) begin bad++; $display("FAIL simul_tx s=%0d got=%b want=%b", s, tx_a, e); end
      if (busy_a === 1'b1) busy_n++;
      if (s == F_A - 1 || s == F_A) begin
        total++; if (cnt_a !== 3'd1) begin bad++; $display("FAIL simul_cnt s=%0d got=%0d want=1", s, cnt_a); end
      end
      start_a = 1'b0;
      if (s == 2)       begin start_a = 1'b1; data_a = q[1]; end
      if (s == F_A - 1) begin start_a = 1'b1; data_a = q[2]; end
    end
    total++; if (busy_n != 3 * F_A) begin bad++; $display("FAIL simul_busy_len got=%0d want=%0d", busy_n, 3 * F_A); end
    $display("simul: frames=3 busy_clocks=%0d", busy_n);
  endtask

  task automatic test_reset_mid();
    logic [8:0] d;
    logic       e;
    d = 9'h0F0;
    @(posedge clk); #1; start_a = 1'b1; data_a = 8'hF0;
    @(posedge clk); #1; start_a = 1'b0;
    for (int s = 0; s < 55; s++) begin
      @(posedge clk); #1;
      e = (s == 0) ? 1'b1 : exp_bit((s - 1) / 16, d, 8, ^d);
      total++; if (tx_a !== e) begin bad++; $display("FAIL rmid_tx s=%0d got=%b want=%b", s, tx_a, e); end
      start_a = (s == 2);
      data_a  = 8'h0F;
    end
    rst_n = 1'b0;
    #1;
    total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL rmid_tx_now got=%b want=1", tx_a); end
    total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL rmid_cnt got=%0d want=0", cnt_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy_a); end
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    for (int s = 0; s < 2 * F_A; s++) begin
      @(posedge clk); #1;
      total++; if ({tx_a, busy_a} !== 2'b10) begin
        bad++; $display("FAIL rmid_residual s=%0d got=%b want=10", s, {tx_a, busy_a});
      end
    end
    $display("reset_mid: line idle after release");
  endtask

  task automatic test_variant();
    logic [8:0] d;
    logic       e;
    int         busy_n;
    d = 9'h041;
    @(posedge clk); #1; start_b = 1'b1; data_b = 7'h41;
    @(posedge clk); #1; start_b = 1'b0;
    busy_n = 0;
    for (int s = 0; s < F_B + 8; s++) begin
      @(posedge clk); #1;
      e = (s == 0 || s > F_B) ? 1'b1 : exp_bit((s - 1) / 8, d, 7, ^d);
      total++; if (tx_b !== e) begin bad++; $display("FAIL variant_tx s=%0d got=%b want=%b", s, tx_b, e); end
      if (busy_b === 1'b1) busy_n++;
    end
    total++; if (busy_n != F_B) begin bad++; $display("FAIL variant_len got=%0d want=%0d", busy_n, F_B); end
    total++; if ({cnt_b, rdy_b} !== 4'b0001) begin bad++; $display("FAIL variant_end got=%b want=0001", {cnt_b, rdy_b}); end
    $display("variant: char=41 frame_clocks=%0d", busy_n);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [8:0] d;
    logic       e, pe;
    int         busy_n;
    d = 9'h007;
    for (int po = 0; po < 2; po++) begin
      pe = (po == 0) ? 1'b1 : 1'b0;
      @(posedge clk); #1; start_a = 1'b1; data_a = 8'h07; par_odd_a = po[0];
      @(posedge clk); #1; start_a = 1'b0;
      busy_n = 0;
      for (int s = 0; s < 176 + 16; s++) begin
        @(posedge clk); #1;
        e = (s == 0 || s > 176) ? 1'b1 : exp_bit((s - 1) / 16, d, 8, pe);
        total++; if (tx_a !== e) begin bad++; $display("FAIL parity_tx po=%0d s=%0d got=%b want=%b", po, s, tx_a, e); end
        if (busy_a === 1'b1) busy_n++;
        if (s == 2) par_odd_a = ~po[0];
      end
      total++; if (busy_n != 176) begin bad++; $display("FAIL parity_len po=%0d got=%0d want=176", po, busy_n); end
      $display("parity: par_odd=%0d parity_bit=%b frame_clocks=%0d", po, pe, busy_n);
    end
    par_odd_a = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; data_a = '0;
    start_b = 1'b0; data_b = '0;
`ifdef UART_TX_PARITY_EN
    par_odd_a = 1'b0; par_odd_b = 1'b0;
`endif
    test_reset();
    test_single();
    test_queue();
    test_simul();
    test_reset_mid();
    test_variant();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter; next generation of the fixed 8N1 transmitter.
- Adds configurable data width, baud divisor and stop-bit count.
- Adds a small transmit FIFO so the host can queue several characters and frames go out back-to-back.
- Sits between the command/response logic and the board TX pin.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first.
- BAUD_DIV, 2604, clocks per serial bit; legal range >=4.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, >=2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- tx_start  input  1  push request; sampled each rising edge
- tx_data  input  DATA_BITS  character to push
- tx_rdy  output  1  FIFO not full; push accepted when tx_start && tx_rdy
- fifo_cnt  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- tx_busy  output  1  high whenever the FSM is not in IDLE
- tx  output  1  serial line; registered; idle level 1
- par_odd  input  1  parity sense, 0 = even, 1 = odd; present only with UART_TX_PARITY_EN

Behaviour:
- Reset (asynchronous) values:
  - tx=1, tx_busy=0, fifo_cnt=0, tx_rdy=1.
  - FIFO pointers cleared; FSM in IDLE; baud and bit counters 0.
  - A reset mid-frame drives tx high immediately and discards all queued data.
- FIFO push:
  - tx_start && tx_rdy writes tx_data at the rising edge.
  - tx_start while full (fifo_cnt==FIFO_DEPTH) is ignored; no data is written and no error is flagged.
- Simultaneous push and pop: occupancy unchanged; both take effect.
- FSM states: IDLE, START, DATA, PARITY (exists only with the macro), STOP.
- IDLE:
  - If fifo_cnt!=0, pop the head into the shift register, clear the baud counter and go to START.
  - Otherwise stay; tx=1.
- Baud tick: the baud counter counts 0..BAUD_DIV-1; tick when it equals BAUD_DIV-1, then it wraps to 0. Each bit is held exactly BAUD_DIV clocks.
- START: tx=0 for one bit time, then go to DATA.
- DATA:
  - Shift out DATA_BITS bits LSB first, one per tick.
  - The bit counter increments per tick. After the last bit, go to PARITY if present, else STOP.
- STOP: tx=1 for STOP_BITS bit times. On the final tick:
  - FIFO nonempty: pop and go directly to START, with no idle clock between frames.
  - FIFO empty: go to IDLE.
- Latency: a push at edge E0 into an empty FIFO with the FSM idle is popped at E1; tx falls after E1.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * BAUD_DIV clocks, where P=1 with parity, else 0.
- tx is a flop output (no glitches). tx_busy is registered with the state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Port par_odd exists and the PARITY state is inserted after DATA for one bit time.
  - Parity bit = ^data ^ par_odd, with data captured at pop. par_odd is sampled at pop and held for the frame.
- Undefined: no par_odd port, no PARITY state; frames are pure xN1/xN2.

Test Plan:
- Single character, DATA_BITS=8, BAUD_DIV=16, STOP_BITS=1: push 0xA5 while idle -> tx falls 2 clocks after the push edge. Then tx holds 0 for 16 clocks, followed by 1,0,1,0,0,1,0,1 at 16 clocks each, then 1 for 16 clocks. tx_busy is high exactly 160 clocks; fifo_cnt returns to 0.
- Queue and overflow, FIFO_DEPTH=4: while a frame is in flight, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> fifo_cnt reaches 4 and tx_rdy drops. 0x55 is dropped. Exactly 4 further frames follow with no idle clock between a stop bit and the next start bit.
- Simultaneous push/pop: fifo_cnt=1, push on the same edge as the STOP-final-tick pop -> fifo_cnt stays 1 and both characters are transmitted in order.
- Reset mid-frame: assert rst_n=0 during the 3rd data bit -> tx=1 within the same cycle, fifo_cnt=0, tx_busy=0. After release, no residual frame appears.
- Width and stop-bit variant, DATA_BITS=7, STOP_BITS=2, BAUD_DIV=8: push 0x41 -> 0, then 1,0,0,0,0,0,1, then 1,1; frame is 80 clocks.
- Parity (UART_TX_PARITY_EN), DATA_BITS=8, BAUD_DIV=16: push 0x07 with par_odd=0 -> parity bit 1; with par_odd=1 -> parity bit 0. Frame is 176 clocks.
